// File: rtl/m3_pkg.sv
// Shared types and default sizing for the m3 serializer slice.
package m3_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/m3_tick_gen.sv
// Bit-period divider: tick is high in the last cycle of every DIV-cycle period.
module m3_tick_gen
  import m3_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(DIV + 1);

  logic [CW-1:0] cnt;

  // Counter never exceeds DIV-1, so it cannot wrap within its width.
  assign tick = !restart && (cnt == CW'(DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/m3_serializer.sv
// MSB-first parallel-to-serial converter holding each bit for DIV cycles,
// with registered bit/frame strobes and a done pulse after the last bit.
module m3_serializer
  import m3_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             bit_stb,
  output logic             frame_start,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [BW-1:0]    bit_cnt;
  logic             restart;
  logic             tick;

  assign shifted = shreg << 1;
  assign ready   = (state == IDLE);
  assign restart = (state != SHIFT);

  m3_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      sout        <= 1'b0;
      bit_stb     <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
    end else begin
      // Strobes default low; only the branches below raise them for one cycle.
      bit_stb     <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shreg       <= din;
            bit_cnt     <= BW'(WIDTH);
            sout        <= din[WIDTH-1];
            bit_stb     <= 1'b1;
            frame_start <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            shreg   <= shifted;
            bit_cnt <= bit_cnt - BW'(1);
            if (bit_cnt == BW'(1)) begin
              sout  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              sout    <= shifted[WIDTH-1];
              bit_stb <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m3_serializer.sv
// Bench for m3_serializer: three parameterisations checked every cycle against
// a cycle-offset reference model, plus directed frame scenarios.
module tb_m3_serializer;

  localparam int WS [3] = '{8, 8, 1};
  localparam int DS [3] = '{4, 1, 3};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din   [3];
  logic       load  [3];
  logic       ready [3];
  logic       sout  [3];
  logic       stb   [3];
  logic       fs    [3];
  logic       done  [3];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  m3_serializer #(.WIDTH(8), .DIV(4)) u_dut_a (
    .clk(clk), .reset(reset), .din(din[0]), .load(load[0]), .ready(ready[0]),
    .sout(sout[0]), .bit_stb(stb[0]), .frame_start(fs[0]), .done(done[0])
  );

  m3_serializer #(.WIDTH(8), .DIV(1)) u_dut_b (
    .clk(clk), .reset(reset), .din(din[1]), .load(load[1]), .ready(ready[1]),
    .sout(sout[1]), .bit_stb(stb[1]), .frame_start(fs[1]), .done(done[1])
  );

  m3_serializer #(.WIDTH(1), .DIV(3)) u_dut_c (
    .clk(clk), .reset(reset), .din(din[2][0:0]), .load(load[2]), .ready(ready[2]),
    .sout(sout[2]), .bit_stb(stb[2]), .frame_start(fs[2]), .done(done[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: per instance, cycles elapsed since the accepting edge (-1 = idle).
  int         t     [3] = '{-1, -1, -1};
  logic [7:0] mdata [3];

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        t[i] <= -1;
      end else if (t[i] < 0) begin
        if (load[i]) begin
          t[i]     <= 1;
          mdata[i] <= din[i];
        end
      end else begin
        t[i] <= (t[i] >= WS[i] * DS[i] + 1) ? -1 : t[i] + 1;
      end
    end
  end

  // Expected {ready, sout, bit_stb, frame_start, done} from the frame offset alone.
  function automatic logic [4:0] exp_out(input int i);
    int w = WS[i];
    int d = DS[i];
    int k = t[i];
    if (k < 0) return 5'b10000;
    if (k <= w * d)
      return {1'b0, mdata[i][w - 1 - (k - 1) / d], ((k - 1) % d) == 0, k == 1, 1'b0};
    return 5'b00001;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++)
      check($sformatf("cyc%0d_u%0d_rdy_sout_stb_fs_done", cyc, i),
            {27'd0, ready[i], sout[i], stb[i], fs[i], done[i]}, {27'd0, exp_out(i)});
  end

  // Downstream "1001" detector on instance A: cleared by frame_start, sampled on bit_stb.
  logic [3:0] hist;
  logic       det;
  assign det = (hist == 4'b1001);

  always @(posedge clk or posedge reset) begin
    if (reset)        hist <= '0;
    else if (stb[0])  hist <= fs[0] ? {3'b000, sout[0]} : {hist[2:0], sout[0]};
  end

  // Loads d into instance i, then observes ncyc cycles (rel=1 is the cycle after the accepting edge).
  task automatic run_frame(input int i, input logic [7:0] d, input bit hold,
                           input int pulse_at, input logic [7:0] pulse_d, input int ncyc,
                           output logic [7:0] bits, output int nstb, output int fs_c,
                           output int fs2_c, output int done_c, output int ready_c,
                           output bit det_at_done);
    @(negedge clk);
    din[i]  = d;
    load[i] = 1'b1;
    bits = '0; nstb = 0; fs_c = -1; fs2_c = -1; done_c = -1; ready_c = -1; det_at_done = 1'b0;
    for (int rel = 1; rel <= ncyc; rel++) begin
      @(negedge clk);
      load[i] = hold || (rel == pulse_at);
      din[i]  = (rel == pulse_at) ? pulse_d : d;
      if (stb[i] && done_c < 0) begin
        bits = {bits[6:0], sout[i]};
        nstb++;
      end
      if (fs[i]) begin
        if (fs_c < 0)       fs_c  = rel;
        else if (fs2_c < 0) fs2_c = rel;
      end
      if (done[i] && done_c < 0) begin
        done_c      = rel;
        det_at_done = det;
      end
      if (ready[i] && ready_c < 0) ready_c = rel;
    end
    load[i] = 1'b0;
  endtask

  logic [7:0] bits;
  int         nstb, fs_c, fs2_c, done_c, ready_c, nd;
  bit         dd;

  initial begin
    for (int i = 0; i < 3; i++) begin
      load[i] = 1'b0;
      din[i]  = '0;
    end
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_u%0d", i),
            {27'd0, ready[i], sout[i], stb[i], fs[i], done[i]}, 32'b10000);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    // Basic frame 0xB4, WIDTH=8, DIV=4
    run_frame(0, 8'hB4, 1'b0, -1, 8'h00, 40, bits, nstb, fs_c, fs2_c, done_c, ready_c, dd);
    check("b4_bits", bits, 8'hB4);
    check("b4_nstb", nstb, 8);
    check("b4_fs", fs_c, 1);
    check("b4_done", done_c, 33);
    check("b4_ready", ready_c, 34);

    // load pulsed mid-frame must be ignored
    run_frame(0, 8'h03, 1'b0, 10, 8'hFF, 40, bits, nstb, fs_c, fs2_c, done_c, ready_c, dd);
    check("ign_bits", bits, 8'h03);
    check("ign_done", done_c, 33);
    check("ign_no_frame2", fs2_c, -1);

    // DIV=1 with load held high
    run_frame(1, 8'h06, 1'b1, -1, 8'h00, 12, bits, nstb, fs_c, fs2_c, done_c, ready_c, dd);
    check("div1_bits", bits, 8'h06);
    check("div1_nstb", nstb, 8);
    check("div1_done", done_c, 9);
    check("div1_ready", ready_c, 10);
    check("div1_frame2", fs2_c, 11);
    repeat (15) @(negedge clk);

    // Reset during bit 3 of 0x5A
    @(negedge clk);
    din[0]  = 8'h5A;
    load[0] = 1'b1;
    @(negedge clk);
    load[0] = 1'b0;
    repeat (13) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_outs", {28'd0, sout[0], stb[0], fs[0], done[0]}, 32'd0);
    check("rst_mid_ready", {31'd0, ready[0]}, 32'd1);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    nd = 0;
    repeat (40) @(negedge clk) if (done[0]) nd++;
    check("rst_no_done", nd, 0);
    run_frame(0, 8'h5A, 1'b0, -1, 8'h00, 40, bits, nstb, fs_c, fs2_c, done_c, ready_c, dd);
    check("rst_after_bits", bits, 8'h5A);
    check("rst_after_done", done_c, 33);

    // WIDTH=1, DIV=3
    run_frame(2, 8'h01, 1'b0, -1, 8'h00, 8, bits, nstb, fs_c, fs2_c, done_c, ready_c, dd);
    check("w1_bits", bits, 8'h01);
    check("w1_nstb", nstb, 1);
    check("w1_fs", fs_c, 1);
    check("w1_done", done_c, 4);
    check("w1_ready", ready_c, 5);

    // Downstream detector
    run_frame(0, 8'h09, 1'b0, -1, 8'h00, 40, bits, nstb, fs_c, fs2_c, done_c, ready_c, dd);
    check("det_09", {31'd0, dd}, 32'd1);
    run_frame(0, 8'h0A, 1'b0, -1, 8'h00, 40, bits, nstb, fs_c, fs2_c, done_c, ready_c, dd);
    check("det_0a", {31'd0, dd}, 32'd0);

    // Random loads on all instances with occasional short resets
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        load[i] = ($urandom_range(0, 3) == 0);
        din[i]  = 8'($urandom);
      end
      if ($urandom_range(0, 99) == 0) begin
        #1 reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) load[i] = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/m3_serializer.md
M3_SERIALIZER -- requirements
Module: m3_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per frame (legal range 1..32).
REQ-002 SHALL have parameter DIV, default 4, clock cycles each bit is held (legal range 1..255).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port din, input, WIDTH, parallel word to serialize.
REQ-006 SHALL have port load, input, 1, request to capture din.
REQ-007 SHALL have port ready, output, 1, high when a load will be accepted.
REQ-008 SHALL have port sout, output, 1, serial bit stream, MSB first; feeds the downstream detector's inp.
REQ-009 SHALL have port bit_stb, output, 1, one-cycle strobe marking the first cycle of each bit period.
REQ-010 SHALL have port frame_start, output, 1, one-cycle strobe coincident with bit_stb of the MSB; the downstream detector uses it to clear its state.
REQ-011 SHALL have port done, output, 1, one-cycle pulse after the last bit period ends.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL drive ready high only in IDLE.
REQ-014 SHALL, when load=1 and the FSM is in IDLE at edge N, capture din into the shift register, set the bit counter to WIDTH, clear the divider, and enter SHIFT.
REQ-015 SHALL, in cycle N+1, present din[WIDTH-1] on sout with bit_stb=1 and frame_start=1.
REQ-016 SHALL hold each bit on sout for exactly DIV cycles.
REQ-017 SHALL assert bit_stb only in the first cycle of each bit period.
REQ-018 SHALL, at the end of each bit period, shift left one position and decrement the bit counter.
REQ-019 SHALL enter DONE after WIDTH*DIV cycles in SHIFT, so that done=1 in cycle N+1+WIDTH*DIV.
REQ-020 SHALL return to IDLE one cycle after entering DONE, so that ready=1 again in cycle N+2+WIDTH*DIV.
REQ-021 SHALL ignore load in SHIFT and DONE, with no capture and no effect on the frame in progress.
REQ-022 SHALL drive sout=0 in IDLE and DONE.
REQ-023 SHALL, for DIV=1, assert bit_stb on every SHIFT cycle.
REQ-024 SHALL, for WIDTH=1, produce one bit period followed by done.
REQ-025 SHALL make the divider counter ceil(log2(DIV+1)) bits wide and the bit counter ceil(log2(WIDTH+1)) bits wide, with no wrap beyond those bounds.
REQ-026 SHALL, when load stays high continuously, start a new frame on the first IDLE cycle, giving a two-cycle gap (DONE, IDLE) between frames.

Reset
REQ-027 SHALL, on reset=1, immediately and asynchronously force: state=IDLE, shift register=0, both counters=0, sout=0, bit_stb=0, frame_start=0, done=0, ready=1.
REQ-028 SHALL, when reset is asserted mid-frame, abort the frame with no done pulse, and accept no load until the first edge after reset deasserts.

Structure
REQ-029 SHALL place the state enum (IDLE/SHIFT/DONE) and the default WIDTH/DIV constants in a shared package m3_pkg.
REQ-030 SHALL implement the bit-period divider as a sub-module m3_tick_gen (inputs clk, reset, restart; output tick at the end of each DIV-cycle period).
REQ-031 SHALL register all outputs except ready, which is decoded from state.

Verification
REQ-032 SHALL test: WIDTH=8, DIV=4, load 0xB4 at edge 0 -> sout 1,0,1,1,0,1,0,0, each bit held 4 cycles; frame_start in cycle 1; done in cycle 33; ready in cycle 34.
REQ-033 SHALL test: load pulsed with din=0xFF in cycle 10 of a frame carrying 0x03 -> stream is still 0,0,0,0,0,0,1,1, and no second frame starts.
REQ-034 SHALL test: DIV=1, load held high with din=0x06 -> sout 0,0,0,0,0,1,1,0 on consecutive cycles, bit_stb high on all 8 cycles, then done, then IDLE, then the next frame.
REQ-035 SHALL test: reset asserted during bit 3 of frame 0x5A -> outputs zero in the same cycle, ready=1, no done; a later load of 0x5A runs a full correct frame.
REQ-036 SHALL test: WIDTH=1, DIV=3, load 1 -> sout=1 for 3 cycles with frame_start in the first, done in the next cycle.
REQ-037 SHALL test: downstream detector connected (inp=sout, cleared on frame_start, sampled on bit_stb), frames 0x09 and 0x0A -> detector output 1 for 0x09 and 0 for 0x0A at frame end.
